uart_tx_ctl: RTL and testbench

//  UART transmit path, the counterpart of the receive control block.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_ctl_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_ctl.sv | 114 +++++++++++
 tb/tb_uart_tx_ctl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and baud helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // Clocks per bit; integer division, so the line rate rounds slightly fast.
    function automatic int bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_ctl_if.sv
// rtl/uart_tx_ctl_if.sv - host write port of the UART transmitter
interface uart_tx_ctl_if;
    import uart_pkg::*;

    logic                      Wr_En;
    logic [UART_DATA_BITS-1:0] Wr_Data;
    logic                      Full;

    modport master (output Wr_En, output Wr_Data, input Full);
    modport slave  (input Wr_En, input Wr_Data, output Full);

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - small synchronous FIFO buffering bytes awaiting transmission
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Full is taken from the registered count, so a push is refused while full
    // even if a pop frees an entry in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_ctl.sv
// rtl/uart_tx_ctl.sv - UART 8N1 transmitter: byte FIFO feeding a start/data/stop serialiser
module uart_tx_ctl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    uart_tx_ctl_if.slave  bus,
    output logic          TX_Busy,
    output logic          TX_Done_Sig,
    output logic          TX_Pin_Out
);

    localparam int                 BPS_CNT   = bps_cnt(CLK_FREQ, BAUD);
    localparam int                 BAUD_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(BPS_CNT - 1);
    localparam logic [2:0]         BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_t               state, state_nxt;
    logic [BAUD_W-1:0]         baud_cnt, baud_nxt;
    logic [2:0]                bit_cnt, bit_nxt;
    logic [UART_DATA_BITS-1:0] shift_q, shift_nxt;
    logic                      pin_q, pin_d;
    logic                      baud_end;
    logic                      pop;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .push  (bus.Wr_En),
        .din   (bus.Wr_Data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.Full   = fifo_full;
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign TX_Pin_Out = pin_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            pin_q    <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift_q  <= shift_nxt;
            pin_q    <= pin_d;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        baud_nxt  = baud_end ? '0 : baud_cnt + BAUD_W'(1);
        case (state)
            ST_IDLE: begin
                baud_nxt = '0;
                if (!fifo_empty) begin
                    state_nxt = ST_START;
                    shift_nxt = fifo_dout;
                    bit_nxt   = '0;
                end
            end
            ST_START: begin
                if (baud_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = ST_STOP;
                    end else begin
                        shift_nxt = shift_q >> 1;
                        bit_nxt   = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                if (baud_end) state_nxt = ST_IDLE;
            end
        endcase
        if (state_nxt != state) baud_nxt = '0;
    end

    // The line level is computed from the upcoming state so the registered pin
    // switches on the same edge as the state it belongs to.
    always_comb begin
        pop         = (state == ST_IDLE) && !fifo_empty;
        TX_Busy     = (state != ST_IDLE);
        TX_Done_Sig = (state == ST_STOP) && baud_end;
        case (state_nxt)
            ST_START: pin_d = 1'b0;
            ST_DATA:  pin_d = shift_nxt[0];
            default:  pin_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctl.sv
// tb/tb_uart_tx_ctl.sv - scoreboard bench for uart_tx_ctl with a line-decoding monitor
module tb_uart_tx_ctl;

    logic CLK;
    logic RSTn;
    logic TX_Busy;
    logic TX_Done_Sig;
    logic TX_Pin_Out;

    uart_tx_ctl_if bus();

    uart_tx_ctl #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .bus         (bus),
        .TX_Busy     (TX_Busy),
        .TX_Done_Sig (TX_Done_Sig),
        .TX_Pin_Out  (TX_Pin_Out)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         exp_done = 0;
    bit         mon_en = 1;
    int         last_start = -1;
    int         mstate = 0;
    int         mcnt = 0;
    int         cyc = 0;
    logic [7:0] mbyte;
    logic       prev_pin = 1'b1;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit acc);
        bus.Wr_En   = 1'b1;
        bus.Wr_Data = d;
        if (acc) begin
            exp_q.push_back(d);
            exp_done++;
        end
        @(negedge CLK);
        bus.Wr_En   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && mstate == 0 && !TX_Busy) begin
                ok = 1;
                break;
            end
        end
        check({"idle_", name}, ok, 1);
        check({"done_count_", name}, done_cnt, exp_done);
    endtask

    // Monitor: decodes frames from the line, sampling mid-bit, and scores them
    // against the expected-byte queue.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (RSTn && TX_Done_Sig) done_cnt++;
            if (!RSTn || !mon_en) begin
                mstate   = 0;
                prev_pin = 1'b1;
            end else begin
                if (mstate == 0) begin
                    if (prev_pin && !TX_Pin_Out) begin
                        mstate = 1;
                        mcnt   = 0;
                        if (last_start >= 0) check("start_gap", cyc - last_start, 101);
                        last_start = cyc;
                    end
                end else begin
                    mcnt++;
                    if (mcnt == 5) begin
                        check("start_bit", TX_Pin_Out, 0);
                    end else if (mcnt >= 15 && mcnt <= 85 && (mcnt % 10) == 5) begin
                        mbyte[(mcnt - 15) / 10] = TX_Pin_Out;
                    end else if (mcnt == 95) begin
                        check("stop_bit", TX_Pin_Out, 1);
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_frame: got %0h expected none", mbyte);
                        end else begin
                            check("frame_byte", mbyte, exp_q.pop_front());
                        end
                    end else if (mcnt == 99) begin
                        check("done_at_stop_end", TX_Done_Sig, 1);
                        mstate = 0;
                    end
                end
                prev_pin = TX_Pin_Out;
            end
        end
    end

    initial begin
        #500000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        bit bad;
        int d0;
        RSTn        = 1'b0;
        bus.Wr_En   = 1'b0;
        bus.Wr_Data = 8'h00;

        // 1: reset state and idle line
        repeat (5) @(negedge CLK);
        check("rst_pin", TX_Pin_Out, 1);
        RSTn = 1'b1;
        @(negedge CLK);
        check("rel_pin", TX_Pin_Out, 1);
        check("rel_full", bus.Full, 0);
        check("rel_busy", TX_Busy, 0);
        check("rel_done", TX_Done_Sig, 0);
        bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if (TX_Pin_Out !== 1'b1) bad = 1;
        end
        check("idle_line_50", bad, 0);

        // 2: single byte, start-bit latency
        last_start = -1;
        push(8'hA5, 1);
        check("start_lat_1clk", TX_Pin_Out, 1);
        @(negedge CLK);
        check("start_lat_2clk", TX_Pin_Out, 0);
        check("busy_in_frame", TX_Busy, 1);
        wait_idle("single", 200);
        check("busy_after", TX_Busy, 0);

        // 3: back-to-back frames
        last_start = -1;
        push(8'h00, 1);
        push(8'hFF, 1);
        push(8'h55, 1);
        wait_idle("b2b", 500);

        // 4: overflow, sixth byte dropped
        last_start = -1;
        push(8'h01, 1);
        push(8'h02, 1);
        push(8'h03, 1);
        push(8'h04, 1);
        check("full_before_4th", bus.Full, 0);
        push(8'h05, 1);
        check("full_after_4", bus.Full, 1);
        push(8'h06, 0);
        check("full_hold", bus.Full, 1);
        wait_idle("overflow", 700);
        check("full_drained", bus.Full, 0);

        // 5: reset during data bit 3 of 8'h3C with two bytes queued
        mon_en = 0;
        push(8'h3C, 0);
        push(8'hAA, 0);
        push(8'hBB, 0);
        repeat (44) @(negedge CLK);
        check("bit3_of_3c", TX_Pin_Out, 1);
        check("busy_pre_rst", TX_Busy, 1);
        check("full_pre_rst", bus.Full, 0);
        d0 = done_cnt;
        RSTn = 1'b0;
        #1;
        check("midrst_pin", TX_Pin_Out, 1);
        check("midrst_busy", TX_Busy, 0);
        check("midrst_done", TX_Done_Sig, 0);
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        bad = 0;
        repeat (1200) begin
            @(negedge CLK);
            if (TX_Pin_Out !== 1'b1 || TX_Busy !== 1'b0) bad = 1;
        end
        check("no_frames_after_rst", bad, 0);
        check("no_done_after_rst", done_cnt, d0);
        mon_en = 1;

        // 6: push in the same cycle as an IDLE pop with one byte buffered
        last_start = -1;
        push(8'h10, 1);
        push(8'h11, 1);
        bad = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (TX_Done_Sig) begin
                bad = 0;
                break;
            end
        end
        check("wait_done_10", bad, 0);
        @(negedge CLK);
        push(8'h77, 1);
        check("full_cnt1", bus.Full, 0);
        push(8'h78, 1);
        check("full_cnt2", bus.Full, 0);
        push(8'h79, 1);
        check("full_cnt3", bus.Full, 0);
        push(8'h7A, 1);
        check("full_cnt4", bus.Full, 1);
        push(8'h7B, 0);
        wait_idle("pushpop", 900);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
